// File: rtl/vend_pkg.sv
// Shared types, coin/product codes and value lookups
// for the vending transaction sequencer.
package vend_pkg;

  localparam int BAL_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam logic [2:0] COIN_5  = 3'b001;
  localparam logic [2:0] COIN_10 = 3'b010;
  localparam logic [2:0] COIN_25 = 3'b100;

  localparam logic [3:0] PROD_15 = 4'b0001;
  localparam logic [3:0] PROD_20 = 4'b0010;
  localparam logic [3:0] PROD_25 = 4'b0100;
  localparam logic [3:0] PROD_30 = 4'b1000;

  // Non one-hot codes map to 0.
  function automatic logic [BAL_W-1:0] coin_value(
    input logic [2:0] c
  );
    case (c)
      COIN_5:  return BAL_W'(5);
      COIN_10: return BAL_W'(10);
      COIN_25: return BAL_W'(25);
      default: return '0;
    endcase
  endfunction

  function automatic logic [BAL_W-1:0] product_price(
    input logic [3:0] p
  );
    case (p)
      PROD_15: return BAL_W'(15);
      PROD_20: return BAL_W'(20);
      PROD_25: return BAL_W'(25);
      PROD_30: return BAL_W'(30);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_edge_detect.sv
// Registers a level input; evt pulses one cycle when it goes
// from all-zero to any bit set. Ports: clk, rst_n, din -> evt, value.
module vend_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic         evt,
  output logic [W-1:0] value
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      prev  <= '0;
    end else begin
      value <= din;
      prev  <= value;
    end
  end

  assign evt = (|value) && !(|prev);

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: button events in; balance, cost,
// dispense/change pulses, coin_reject and debug state out.
module vend_controller
  import vend_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 10,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [2:0]       coin,
  input  logic [3:0]       product,
  input  logic             cancel,
  output logic [BAL_W-1:0] balance,
  output logic [BAL_W-1:0] cost,
  output logic             dispense,
  output logic [BAL_W-1:0] change,
  output logic             change_valid,
  output logic             coin_reject,
  output logic [1:0]       state
);

  logic       coin_evt;
  logic [2:0] coin_q;
  logic       prod_evt;
  logic [3:0] prod_q;
  logic       cancel_evt;
  logic       cancel_unused;

  vend_edge_detect #(.W(3)) u_coin (
    .clk   (clk),
    .rst_n (reset),
    .din   (coin),
    .evt   (coin_evt),
    .value (coin_q)
  );

  vend_edge_detect #(.W(4)) u_prod (
    .clk   (clk),
    .rst_n (reset),
    .din   (product),
    .evt   (prod_evt),
    .value (prod_q)
  );

  vend_edge_detect #(.W(1)) u_cancel (
    .clk   (clk),
    .rst_n (reset),
    .din   (cancel),
    .evt   (cancel_evt),
    .value (cancel_unused)
  );

  state_t           st, st_n;
  logic [BAL_W-1:0] bal_n, cost_n, chg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rej_n;
  logic [BAL_W-1:0] cval, pval;
  logic             coin_ok, prod_ok;

  assign cval    = coin_value(coin_q);
  assign pval    = product_price(prod_q);
  assign coin_ok = coin_evt && (cval != '0);
  assign prod_ok = prod_evt && (pval != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      balance     <= '0;
      cost        <= '0;
      change      <= '0;
      cnt         <= '0;
      coin_reject <= 1'b0;
    end else begin
      st          <= st_n;
      balance     <= bal_n;
      cost        <= cost_n;
      change      <= chg_n;
      cnt         <= cnt_n;
      coin_reject <= rej_n;
    end
  end

  always_comb begin
    st_n   = st;
    bal_n  = balance;
    cost_n = cost;
    chg_n  = change;
    cnt_n  = cnt;
    rej_n  = 1'b0;
    case (st)
      IDLE: begin
        bal_n  = '0;
        cost_n = '0;
        chg_n  = '0;
        cnt_n  = '0;
        rej_n  = coin_evt;
        if (prod_ok) begin
          cost_n = pval;
          st_n   = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel_evt) begin
          // A coin landing with cancel is refunded too.
          st_n  = CHANGE;
          chg_n = balance + (coin_ok ? cval : '0);
          rej_n = coin_evt && !coin_ok;
        end else if (cnt == CNT_W'(TIMEOUT_TICKS)) begin
          st_n  = CHANGE;
          chg_n = balance;
          rej_n = coin_evt;
        end else begin
          if (clk_en)
            cnt_n = cnt + CNT_W'(1);
          if (coin_ok) begin
            bal_n = balance + cval;
            cnt_n = '0;
          end else if (coin_evt) begin
            rej_n = 1'b1;
          end
          if (prod_ok && balance == '0)
            cost_n = pval;
          // Compare the registered balance, so payment
          // completes one cycle after the last coin lands.
          if (balance >= cost)
            st_n = DISPENSE;
        end
      end
      DISPENSE: begin
        chg_n = balance - cost;
        rej_n = coin_evt;
        st_n  = CHANGE;
      end
      CHANGE: begin
        bal_n  = '0;
        cost_n = '0;
        chg_n  = '0;
        cnt_n  = '0;
        rej_n  = coin_evt;
        st_n   = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  assign dispense     = (st == DISPENSE);
  assign change_valid = (st == CHANGE);
  assign state        = st;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with hand-computed
// expectations; prints one TB_RESULT summary line.
module tb_vend_controller;

  logic       clk;
  logic       reset;
  logic       clk_en;
  logic [2:0] coin;
  logic [3:0] product;
  logic       cancel;
  logic [7:0] balance;
  logic [7:0] cost;
  logic       dispense;
  logic [7:0] change;
  logic       change_valid;
  logic       coin_reject;
  logic [1:0] state;

  int checks;
  int failures;
  int n_disp;
  int n_cv;

  vend_controller #(
    .TIMEOUT_TICKS (3),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .coin         (coin),
    .product      (product),
    .cancel       (cancel),
    .balance      (balance),
    .cost         (cost),
    .dispense     (dispense),
    .change       (change),
    .change_valid (change_valid),
    .coin_reject  (coin_reject),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dispense) n_disp++;
    if (change_valid) n_cv++;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle press; returns just after the edge that acts on it.
  task automatic press(
    input logic [2:0] c,
    input logic [3:0] p,
    input logic       x
  );
    coin    = c;
    product = p;
    cancel  = x;
    tick();
    coin    = '0;
    product = '0;
    cancel  = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_disp   = 0;
    n_cv     = 0;
    reset    = 1'b0;
    clk_en   = 1'b0;
    coin     = '0;
    product  = '0;
    cancel   = 1'b0;
    repeat (2) tick();
    check("rst_state", 32'(state), 0);
    check("rst_bal", 32'(balance), 0);
    check("rst_cost", 32'(cost), 0);
    check("rst_chg", 32'(change), 0);
    check("rst_pulses", 32'({dispense, change_valid, coin_reject}), 0);
    reset = 1'b1;
    tick();

    // exact payment: 20 with two 10s
    press(3'b000, 4'b0010, 1'b0);
    check("s1_cost", 32'(cost), 20);
    check("s1_state", 32'(state), 1);
    press(3'b010, 4'b0000, 1'b0);
    check("s1_bal10", 32'(balance), 10);
    press(3'b010, 4'b0000, 1'b0);
    check("s1_bal20", 32'(balance), 20);
    check("s1_still", 32'(state), 1);
    tick();
    check("s1_disp_st", 32'(state), 2);
    check("s1_disp", 32'(dispense), 1);
    tick();
    check("s1_chg_st", 32'(state), 3);
    check("s1_cv", 32'(change_valid), 1);
    check("s1_chg", 32'(change), 0);
    tick();
    check("s1_idle", 32'(state), 0);
    check("s1_bal0", 32'(balance), 0);
    check("s1_cost0", 32'(cost), 0);
    check("s1_ndisp", 32'(n_disp), 1);

    // overpay: 15 with 10 + 25
    press(3'b000, 4'b0001, 1'b0);
    check("s2_cost", 32'(cost), 15);
    press(3'b010, 4'b0000, 1'b0);
    press(3'b100, 4'b0000, 1'b0);
    check("s2_bal", 32'(balance), 35);
    tick();
    check("s2_disp", 32'(dispense), 1);
    tick();
    check("s2_cv", 32'(change_valid), 1);
    check("s2_chg", 32'(change), 20);
    tick();
    check("s2_idle", 32'(state), 0);
    check("s2_chg0", 32'(change), 0);

    // cancel with a same-cycle coin 10
    press(3'b000, 4'b1000, 1'b0);
    press(3'b001, 4'b0000, 1'b0);
    check("s3_bal", 32'(balance), 5);
    press(3'b010, 4'b0000, 1'b1);
    check("s3_state", 32'(state), 3);
    check("s3_cv", 32'(change_valid), 1);
    check("s3_chg", 32'(change), 15);
    tick();
    check("s3_idle", 32'(state), 0);
    check("s3_ndisp", 32'(n_disp), 2);

    // timeout after three ticks
    press(3'b000, 4'b0100, 1'b0);
    press(3'b001, 4'b0000, 1'b0);
    clk_en = 1'b1;
    repeat (3) tick();
    clk_en = 1'b0;
    check("s4_wait", 32'(state), 1);
    tick();
    check("s4_state", 32'(state), 3);
    check("s4_chg", 32'(change), 5);
    tick();
    check("s4_idle", 32'(state), 0);
    check("s4_ndisp", 32'(n_disp), 2);

    // coin in idle is rejected
    press(3'b100, 4'b0000, 1'b0);
    check("s5_rej", 32'(coin_reject), 1);
    check("s5_bal", 32'(balance), 0);
    check("s5_state", 32'(state), 0);
    tick();
    check("s5_rej_end", 32'(coin_reject), 0);

    // invalid coin, reselect, blocked reselect
    press(3'b000, 4'b0010, 1'b0);
    press(3'b011, 4'b0000, 1'b0);
    check("s6_rej", 32'(coin_reject), 1);
    check("s6_bal0", 32'(balance), 0);
    press(3'b000, 4'b1000, 1'b0);
    check("s6_resel", 32'(cost), 30);
    press(3'b010, 4'b0000, 1'b0);
    press(3'b001, 4'b0000, 1'b0);
    check("s6_bal15", 32'(balance), 15);
    press(3'b000, 4'b0001, 1'b0);
    check("s6_keep", 32'(cost), 30);
    check("s6_col", 32'(state), 1);

    // async reset mid-transaction
    #2;
    reset = 1'b0;
    #1;
    check("r_state", 32'(state), 0);
    check("r_bal", 32'(balance), 0);
    check("r_cost", 32'(cost), 0);
    check("r_chg", 32'(change), 0);
    check("r_pulses", 32'({dispense, change_valid, coin_reject}), 0);
    product = 4'b0001;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("r_idle", 32'(state), 0);
    check("r_ncv", 32'(n_cv), 4);

    // button held across reset release gives one event
    tick();
    check("h_cost", 32'(cost), 15);
    check("h_state", 32'(state), 1);
    tick();
    product = '0;
    check("h_once", 32'(cost), 15);
    press(3'b000, 4'b0000, 1'b1);
    check("h_cancel", 32'(state), 3);
    check("h_chg", 32'(change), 0);
    tick();
    check("h_idle", 32'(state), 0);
    check("h_ncv", 32'(n_cv), 5);
    check("h_ndisp", 32'(n_disp), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the vending machine. Converts raw coin and product button levels into single events, latches the selected product's price, and accumulates inserted coins. Decides dispense, cancel and timeout, then issues a one-cycle dispense pulse and a change amount. Sits between the board inputs and the display path: `balance` and `cost` feed the 4-to-1 nibble mux for the seven-segment digits.

## Interface
Parameters:
- `TIMEOUT_TICKS`, default 10: `clk_en` ticks without a coin event in COLLECT before auto-cancel.
- `CNT_W`, default 8: width of the timeout counter; must hold `TIMEOUT_TICKS`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `clk_en`  in  1  one-cycle tick from the clock divider; used only for timeout counting.
- `coin`  in  3  coin button level. 3'b001 = 5, 3'b010 = 10, 3'b100 = 25.
- `product`  in  4  product button level. 4'b0001 = 15, 4'b0010 = 20, 4'b0100 = 25, 4'b1000 = 30.
- `cancel`  in  1  cancel button level.
- `balance`  out  8  binary sum of accepted coins.
- `cost`  out  8  latched price of the selected product; 0 when none is selected.
- `dispense`  out  1  one-cycle pulse when the product is released.
- `change`  out  8  refund amount; valid only while `change_valid` = 1.
- `change_valid`  out  1  one-cycle pulse; marks the end of every transaction.
- `coin_reject`  out  1  one-cycle pulse when a coin event is not accepted.
- `state`  out  2  current FSM state, for debug and LEDs.

## Operation
- Event detection:
  - Each input is registered every `clk`.
  - An event is previous value == 0 and current value != 0 (rising edge of "any bit set"), evaluated on the registered value.
  - Events are one `clk` cycle wide.
  - Coin values other than the three legal one-hot codes are invalid. Product values other than the four legal one-hot codes are invalid.
- States, with encoding IDLE = 0, COLLECT = 1, DISPENSE = 2, CHANGE = 3:
  - IDLE:
    - `balance` = 0 and `cost` = 0.
    - A valid product event latches its price into `cost` and moves to COLLECT.
    - Any coin event pulses `coin_reject`.
    - Invalid product events and `cancel` are ignored.
  - COLLECT, evaluated in this priority order:
    - `cancel` event: go to CHANGE with `change` = `balance` plus the value of any same-cycle valid coin.
    - Timeout counter == `TIMEOUT_TICKS`: go to CHANGE with `change` = `balance`.
    - Valid coin event: `balance` += value and the timeout counter is cleared. Invalid coin event: pulse `coin_reject`.
    - Valid product event while `balance` == 0: replace `cost` (reselect). While `balance` > 0 the product event is ignored.
    - When registered `balance` >= `cost`, go to DISPENSE.
  - DISPENSE: assert `dispense` for one cycle, compute `change` = `balance` - `cost`, go to CHANGE.
  - CHANGE: assert `change_valid` for one cycle; clear `balance`, `cost` and the timeout counter; go to IDLE.
- Arithmetic:
  - Maximum `balance` is 30 - 5 + 25 = 50, so the 8-bit width never overflows. No saturation logic.
  - `balance` - `cost` is never negative in DISPENSE.
- Timeout counter:
  - Increments on `clk_en` only while in COLLECT.
  - Clears on any accepted coin and on entry to COLLECT.
- Events arriving in DISPENSE or CHANGE are dropped. A coin event in those states pulses `coin_reject`.

## Timing
- Reset (`reset` = 0): state IDLE. All outputs 0: `balance`, `cost`, `change`, `dispense`, `change_valid`, `coin_reject` and `state`. Input history registers are cleared.
- Reset mid-transaction discards `balance` with no `change_valid`. A button held across reset release produces one event.
- Input latency:
  - Button level at edge n is registered at edge n+1, and the event is acted on at edge n+2.
  - `balance` and `cost` update at edge n+2.
  - `coin_reject` is high during cycle n+2 → n+3.
- Exact payment, where the coin at edge k completes the price:
  - Edge k: `balance` updates.
  - Edge k+1: state becomes DISPENSE; `dispense` is high for cycle k+1 → k+2.
  - Edge k+2: state becomes CHANGE; `change_valid` is high for cycle k+2 → k+3.
  - Edge k+3: state returns to IDLE.
- Cancel path: the cancel event at edge c puts the FSM in CHANGE at c; `change_valid` is high during c → c+1.
- `change` holds its value from its assignment through the `change_valid` cycle, then returns to 0 at the IDLE entry.

## Structure
- Package `vend_pkg`:
  - State enum/localparams.
  - Coin codes with values 5, 10 and 25.
  - Product codes with prices 15, 20, 25 and 30.
  - `BAL_W` = 8.
  - Two functions: `coin_value` (returns 0 for an invalid code) and `product_price` (returns 0 for an invalid code).
- Sub-module `vend_edge_detect` (parameter `W`):
  - Registers a W-bit level input.
  - Outputs a one-cycle `event` pulse and the registered `value`.
  - Three instances: coin, product, cancel.

## Test plan
- Reset, product 4'b0010, then coin 10 twice → `cost` = 20, `balance` 10 then 20; `dispense` pulses once; `change_valid` pulses with `change` = 0; `balance`/`cost` return to 0.
- Product 4'b0001, then coins 10 and 25 → `balance` = 35; `dispense` pulses; `change` = 20.
- Product 4'b1000, coin 5, then `cancel` in the same cycle as a coin-10 event → no `dispense`; `change` = 15.
- Product 4'b0100, coin 5, `TIMEOUT_TICKS` = 3 with `clk_en` pulsed three times and no coins → auto-cancel with `change` = 5.
- Error and reselect cases:
  - Coin 25 in IDLE → `coin_reject` pulses and `balance` stays 0.
  - Coin 3'b011 in COLLECT → `coin_reject` pulses.
  - Reselect: product 4'b1000 at `balance` = 0 updates `cost` to 30.
  - Reselect attempt after a coin is inserted leaves `cost` unchanged.
- Assert `reset` = 0 during COLLECT with `balance` = 15 → all outputs are 0 immediately and asynchronously; no `change_valid`; state is IDLE after release.
